// File: rtl/regfile_pkg.sv
// Shared register-file definitions: index/data widths, register count and the
// write-entry layout used by the write arbiter, register file and control unit.
package regfile_pkg;
  localparam int REG_ADDR_W = 2;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0]     data;
  } wr_entry_t;
endpackage

// File: rtl/regfile_req_fifo.sv
// Per-requester write FIFO. Entries are {key, payload} with the key (target
// register index) in the top KEY_W bits. Every slot's key and valid bit are
// exported so the owner can build a pending-write scoreboard without popping.
module regfile_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 18,
  parameter int KEY_W = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                push_data,
  output logic [W-1:0]                head_data,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            slot_valid,
  output logic [DEPTH-1:0][KEY_W-1:0] slot_key
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rd_ptr;
  logic [AW-1:0]           wr_ptr;
  logic [AW:0]             count;

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    slot_valid = '0;
    slot_key   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_valid[j] = {1'b0, AW'(j) - rd_ptr} < count;
      slot_key[j]   = mem[j][W-1 -: KEY_W];
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file's single write port between
// NUM_REQ writeback producers, with a registered output stage and a
// pending-write mask for hazard detection.
// Optional build macro REGFILE_ARB_STATS_EN adds saturating per-requester
// grant counters (grant_count) and a backpressure cycle counter (stall_count).
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_reg,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  output logic [REG_ADDR_W-1:0]          write_reg,
  output logic [DATA_W-1:0]              write_data,
  output logic                           reg_write,
  output logic [2**REG_ADDR_W-1:0]       pending_mask,
  output logic                           idle
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]          grant_count,
  output logic [15:0]                    stall_count
`endif
);
  localparam int ENT_W = REG_ADDR_W + DATA_W;
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [RR_W-1:0] RR_INIT = RR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]                             fifo_full;
  logic [NUM_REQ-1:0]                             fifo_empty;
  logic [NUM_REQ-1:0]                             push;
  logic [NUM_REQ-1:0]                             pop;
  logic [NUM_REQ-1:0][ENT_W-1:0]                  head;
  logic [NUM_REQ-1:0][FIFO_DEPTH-1:0]             slot_valid;
  logic [NUM_REQ-1:0][FIFO_DEPTH-1:0][REG_ADDR_W-1:0] slot_key;
  logic [RR_W-1:0]                                rr;
  logic [RR_W-1:0]                                gnt_idx;
  logic [RR_W-1:0]                                cand;
  logic                                           gnt_any;

  // Ready never looks at this cycle's pop: a full FIFO stays closed for a cycle.
  assign req_ready = ~fifo_full & {NUM_REQ{~flush}};
  assign push      = req_valid & req_ready;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    regfile_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W),
      .KEY_W (REG_ADDR_W)
    ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .push       (push[i]),
      .pop        (pop[i]),
      .push_data  ({req_reg[i*REG_ADDR_W +: REG_ADDR_W], req_data[i*DATA_W +: DATA_W]}),
      .head_data  (head[i]),
      .full       (fifo_full[i]),
      .empty      (fifo_empty[i]),
      .slot_valid (slot_valid[i]),
      .slot_key   (slot_key[i])
    );
  end

  // Round-robin search from rr+1; walking backwards lets the nearest candidate win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr;
    cand    = rr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = RR_W'((int'(rr) + k) % NUM_REQ);
      if (!fifo_empty[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (flush) gnt_any = 1'b0;
  end

  // One-hot pop of the winning FIFO.
  always_comb begin
    pop = '0;
    if (gnt_any) pop[gnt_idx] = 1'b1;
  end

  // Output stage: load the winner's head; index/data hold when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      rr         <= RR_INIT;
    end else if (flush) begin
      reg_write <= 1'b0;
    end else if (gnt_any) begin
      reg_write               <= 1'b1;
      {write_reg, write_data} <= head[gnt_idx];
      rr                      <= gnt_idx;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Pending-write scoreboard over queued entries plus the staged write.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (slot_valid[i][j]) pending_mask[slot_key[i][j]] = 1'b1;
      end
    end
    if (reg_write) pending_mask[write_reg] = 1'b1;
  end

  assign idle = (&fifo_empty) & ~reg_write;

`ifdef REGFILE_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt;
  logic [15:0]              stall_cnt;

  // Saturating statistics; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (gnt_any && grant_cnt[gnt_idx] != 16'hFFFF)
        grant_cnt[gnt_idx] <= grant_cnt[gnt_idx] + 16'd1;
      if ((|(req_valid & ~req_ready)) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign grant_count = grant_cnt;
  assign stall_count = stall_cnt;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model plus a
// negedge monitor that pops expected writes from a scoreboard.
module tb_regfile_write_arbiter;
  localparam int NR    = 3;
  localparam int DEPTH = 2;
  localparam int DW    = 16;
  localparam int RW    = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*RW-1:0]  req_reg = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [RW-1:0]     write_reg;
  logic [DW-1:0]     write_data;
  logic              reg_write;
  logic [3:0]        pending_mask;
  logic              idle;
`ifdef REGFILE_ARB_STATS_EN
  logic [NR*16-1:0]  grant_count;
  logic [15:0]       stall_count;
`endif

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .NUM_REQ(NR), .FIFO_DEPTH(DEPTH), .DATA_W(DW), .REG_ADDR_W(RW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .reg_write    (reg_write),
    .pending_mask (pending_mask),
    .idle         (idle)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .grant_count  (grant_count),
    .stall_count  (stall_count)
`endif
  );

  typedef struct {
    logic [RW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[NR][$];
  ent_t          exp_q[$];
  int            last_win;
  bit            stg_valid;
  logic [RW-1:0] stg_reg;
  logic [RW-1:0] held_reg;
  logic [DW-1:0] held_data;
  int            gcnt[NR];
  int            model_stalls;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mq[i].delete();
      gcnt[i] = 0;
    end
    exp_q.delete();
    last_win     = NR - 1;
    stg_valid    = 1'b0;
    stg_reg      = '0;
    held_reg     = '0;
    held_data    = '0;
    model_stalls = 0;
  endtask

  // One clock: drive after negedge, check ready, advance model at posedge.
  task automatic step(input logic [NR-1:0] v, input logic fl, input logic [NR*RW-1:0] r,
                      input logic [NR*DW-1:0] d, output logic [NR-1:0] acc);
    int   w;
    bit   rdy;
    bit   stalled;
    ent_t e;
    req_valid = v;
    flush     = fl;
    req_reg   = r;
    req_data  = d;
    #1;
    acc     = '0;
    stalled = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rdy = (mq[i].size() < DEPTH) && !fl;
      chk("req_ready", 64'(req_ready[i]), 64'(rdy));
      acc[i] = v[i] && rdy;
      if (v[i] && !rdy) stalled = 1'b1;
    end
    if (stalled && model_stalls < 65535) model_stalls++;
    w = -1;
    if (!fl) begin
      for (int k = 1; k <= NR; k++) begin
        if (w < 0 && mq[(last_win + k) % NR].size() > 0) w = (last_win + k) % NR;
      end
    end
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < NR; i++) mq[i].delete();
      stg_valid = 1'b0;
    end else begin
      if (w >= 0) begin
        e = mq[w].pop_front();
        exp_q.push_back(e);
        stg_valid = 1'b1;
        stg_reg   = e.r;
        last_win  = w;
        if (gcnt[w] < 65535) gcnt[w]++;
      end else begin
        stg_valid = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          e.r = r[i*RW +: RW];
          e.d = d[i*DW +: DW];
          mq[i].push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    logic [NR-1:0] a;
    for (int c = 0; c < n; c++) step('0, 1'b0, '0, '0, a);
  endtask

  // Monitor: compare the presented write against the scoreboard each cycle.
  always @(negedge clk) begin : mon
    logic [3:0] pm;
    bit         idl;
    ent_t       e;
    if (reset_n) begin
      pm  = '0;
      idl = !stg_valid;
      for (int i = 0; i < NR; i++) begin
        if (mq[i].size() != 0) idl = 1'b0;
        for (int j = 0; j < mq[i].size(); j++) pm[mq[i][j].r] = 1'b1;
      end
      if (stg_valid) pm[stg_reg] = 1'b1;
      chk("reg_write", 64'(reg_write), 64'(stg_valid));
      if (reg_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h required=none", write_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_reg", 64'(write_reg), 64'(e.r));
          chk("write_data", 64'(write_data), 64'(e.d));
          held_reg  = e.r;
          held_data = e.d;
        end
      end else begin
        chk("hold_reg", 64'(write_reg), 64'(held_reg));
        chk("hold_data", 64'(write_data), 64'(held_data));
      end
      chk("pending_mask", 64'(pending_mask), 64'(pm));
      chk("idle", 64'(idle), 64'(idl));
    end
  end

  initial begin
    logic [NR-1:0]    acc;
    logic [NR-1:0]    v;
    logic [NR*RW-1:0] r;
    logic [NR*DW-1:0] d;
    int               n;
    bit               saw;

    model_reset();
    reset_n = 1'b0;
    #12;
    chk("rst_reg_write", 64'(reg_write), 64'(0));
    chk("rst_pending", 64'(pending_mask), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_write_reg", 64'(write_reg), 64'(0));
    chk("rst_write_data", 64'(write_data), 64'(0));
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(3'b111));
    @(negedge clk);

    // Single write from requester 0
    step(3'b001, 1'b0, {4'b0, 2'd2}, {32'b0, 16'h1234}, acc);
    chk("single_pending_q", 64'(pending_mask), 64'(4'b0100));
    chk("single_no_write_yet", 64'(reg_write), 64'(0));
    idle_steps(1);
    chk("single_write_en", 64'(reg_write), 64'(1));
    chk("single_write_reg", 64'(write_reg), 64'(2));
    chk("single_write_data", 64'(write_data), 64'(16'h1234));
    chk("single_pending_s", 64'(pending_mask), 64'(4'b0100));
    idle_steps(1);
    chk("single_done_we", 64'(reg_write), 64'(0));
    chk("single_done_pm", 64'(pending_mask), 64'(0));

    // Round-robin with all requesters continuously valid
    for (int c = 0; c < 6; c++)
      step(3'b111, 1'b0, {2'd2, 2'd1, 2'd0}, {16'hA002, 16'hA001, 16'hA000}, acc);
    idle_steps(6);

    // Backpressure on requester 1 while requester 0 competes
    n   = 0;
    saw = 1'b0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      r = {2'd0, 2'd3, 2'd1};
      d = {16'h0, 16'(16'hB000 + n), 16'(16'hC000 + c)};
      step(3'b011, 1'b0, r, d, acc);
      if (acc[1]) n++;
      else saw = 1'b1;
    end
    chk("bp_accepted", 64'(n), 64'(3));
    chk("bp_saw_not_ready", 64'(saw), 64'(1));
    idle_steps(8);

    // Flush with entries queued and one staged
    for (int c = 0; c < 3; c++)
      step(3'b111, 1'b0, {2'd3, 2'd2, 2'd1}, {16'hD002, 16'hD001, 16'hD000}, acc);
    step(3'b111, 1'b1, {2'd0, 2'd0, 2'd0}, {16'hDEAD, 16'hDEAD, 16'hDEAD}, acc);
    chk("flush_we", 64'(reg_write), 64'(0));
    chk("flush_pm", 64'(pending_mask), 64'(0));
    chk("flush_idle", 64'(idle), 64'(1));
    idle_steps(4);

    // Asynchronous reset in the middle of a burst
    for (int c = 0; c < 3; c++)
      step(3'b111, 1'b0, {2'd1, 2'd3, 2'd2}, {16'hF002, 16'hF001, 16'hF000}, acc);
    req_valid = '0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we", 64'(reg_write), 64'(0));
    chk("arst_pm", 64'(pending_mask), 64'(0));
    chk("arst_idle", 64'(idle), 64'(1));
    chk("arst_write_reg", 64'(write_reg), 64'(0));
    chk("arst_write_data", 64'(write_data), 64'(0));
    model_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    step(3'b111, 1'b0, {2'd2, 2'd1, 2'd0}, {16'hE002, 16'hE001, 16'hE000}, acc);
    idle_steps(1);
    chk("arst_first_grant", 64'(write_data), 64'(16'hE000));
    idle_steps(4);

    // Randomized traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      v = 3'($urandom_range(0, 7));
      r = 6'($urandom());
      d = 48'({$urandom(), $urandom()});
      step(v, ($urandom_range(0, 15) == 0), r, d, acc);
    end
    idle_steps(10);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

`ifdef REGFILE_ARB_STATS_EN
    for (int c = 0; c < 70000; c++)
      step(3'b001, 1'b0, '0, {32'b0, 16'(c)}, acc);
    idle_steps(2);
    chk("gcnt0_sat", 64'(grant_count[15:0]), 64'(16'hFFFF));
    chk("gcnt1", 64'(grant_count[31:16]), 64'(gcnt[1]));
    chk("gcnt2", 64'(grant_count[47:32]), 64'(gcnt[2]));
    chk("stall_cnt", 64'(stall_count), 64'(model_stalls));
    step('0, 1'b1, '0, '0, acc);
    idle_steps(1);
    chk("gcnt0_after_flush", 64'(grant_count[15:0]), 64'(16'hFFFF));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
